// File: rtl/rect_fill_engine.sv
// Raster core: clears the back buffer to BG_COLOR, then fills clipped rectangles
// from a valid/ready command port, one pixel per clock.
module rect_fill_engine #(
  parameter int         WIDTH    = 320,
  parameter int         HEIGHT   = 240,
  parameter logic [3:0] BG_COLOR = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_x1,
  input  logic [9:0] cmd_y1,
  input  logic [3:0] cmd_color,
  input  logic       cmd_last,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic [3:0] px_data,
  output logic       px_we,
  output logic       done
);

  localparam logic [9:0] X_MAX = 10'(WIDTH - 1);
  localparam logic [9:0] Y_MAX = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_DONE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WAIT_CMD = 2'd2,
    ST_FILL     = 2'd3
  } state_t;

  state_t     state_r;
  logic [9:0] x0_r;
  logic [9:0] x1_r;
  logic [9:0] y1_r;
  logic       last_r;

  logic [9:0] x1_clamp_s;
  logic [9:0] y1_clamp_s;
  logic       empty_s;
  logic       fill_end_s;

  assign cmd_ready = (state_r == ST_WAIT_CMD);

  // Clip the incoming command to the visible frame and flag degenerate rectangles.
  always_comb begin
    x1_clamp_s = cmd_x1;
    y1_clamp_s = cmd_y1;
    if (cmd_x1 > X_MAX) begin
      x1_clamp_s = X_MAX;
    end else begin
      x1_clamp_s = cmd_x1;
    end
    if (cmd_y1 > Y_MAX) begin
      y1_clamp_s = Y_MAX;
    end else begin
      y1_clamp_s = cmd_y1;
    end
    empty_s = (cmd_x0 > x1_clamp_s) || (cmd_y0 > y1_clamp_s);
  end

  // An empty rectangle enters FILL with px_we low, so it finishes after one idle cycle.
  assign fill_end_s = !px_we || ((px_x == x1_r) && (px_y == y1_r));

  // Frame sequencer; px_* always reflect the write being presented this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_DONE;
      done    <= 1'b1;
      px_we   <= 1'b0;
      px_x    <= 10'd0;
      px_y    <= 10'd0;
      px_data <= 4'h0;
      x0_r    <= 10'd0;
      x1_r    <= 10'd0;
      y1_r    <= 10'd0;
      last_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_DONE: begin
          if (start) begin
            state_r <= ST_CLEAR;
            done    <= 1'b0;
            px_we   <= 1'b1;
            px_x    <= 10'd0;
            px_y    <= 10'd0;
            px_data <= BG_COLOR;
          end
        end
        ST_CLEAR: begin
          if (px_x == X_MAX) begin
            if (px_y == Y_MAX) begin
              px_we   <= 1'b0;
              state_r <= ST_WAIT_CMD;
            end else begin
              px_x <= 10'd0;
              px_y <= px_y + 10'd1;
            end
          end else begin
            px_x <= px_x + 10'd1;
          end
        end
        ST_WAIT_CMD: begin
          if (cmd_valid) begin
            x0_r    <= cmd_x0;
            x1_r    <= x1_clamp_s;
            y1_r    <= y1_clamp_s;
            last_r  <= cmd_last;
            state_r <= ST_FILL;
            if (empty_s) begin
              px_we <= 1'b0;
            end else begin
              px_we   <= 1'b1;
              px_x    <= cmd_x0;
              px_y    <= cmd_y0;
              px_data <= cmd_color;
            end
          end
        end
        ST_FILL: begin
          if (fill_end_s) begin
            px_we <= 1'b0;
            if (last_r) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= ST_WAIT_CMD;
            end
          end else if (px_x == x1_r) begin
            px_x <= x0_r;
            px_y <= px_y + 10'd1;
          end else begin
            px_x <= px_x + 10'd1;
          end
        end
        default: begin
          state_r <= ST_DONE;
          done    <= 1'b1;
          px_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: one task per scenario, hand-computed expectations.
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0] cmd_color;
  logic       cmd_last;
  logic [9:0] px_x, px_y;
  logic [3:0] px_data;
  logic       px_we;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  rect_fill_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_last(cmd_last),
    .px_x(px_x), .px_y(px_y), .px_data(px_data), .px_we(px_we), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for cmd_ready, present one command for the accepting edge, then scramble inputs.
  task automatic issue_cmd(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] x1,
                           input logic [9:0] y1, input logic [3:0] c, input logic l,
                           output bit timed_out);
    int k = 0;
    timed_out = 1'b0;
    while (!cmd_ready && k < 100) begin
      step();
      k++;
    end
    if (!cmd_ready) begin
      timed_out = 1'b1;
    end else begin
      cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
      cmd_color = c; cmd_last = l; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmd_x0 = 10'd1; cmd_y0 = 10'd2; cmd_x1 = 10'd3; cmd_y1 = 10'd4;
      cmd_color = 4'hF; cmd_last = ~l;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cmd_valid = 1'b0;
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd0; cmd_y1 = 10'd0;
    cmd_color = 4'h0; cmd_last = 1'b0;
    step(); step();
    reset = 1'b0;
    vectors++;
    if (px_x !== 10'd0 || px_y !== 10'd0 || px_data !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_px: got (%0d,%0d,%0d) want (0,0,0)", px_x, px_y, px_data);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (done !== 1'b1 || px_we !== 1'b0 || cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: done=%b we=%b ready=%b want 1 0 0", i, done, px_we, cmd_ready);
      end
    end
  endtask

  task automatic test_clear();
    int n = 0, ex = 0, ey = 0, lx = -1, ly = -1, bx = 0, by = 0;
    bit bad = 0, data_bad = 0, prev_we = 0, ready_seen = 0, ready_ok = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (px_we !== 1'b1 || px_x !== 10'd0 || px_y !== 10'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_first: we=%b (%0d,%0d) done=%b want 1 (0,0) 0", px_we, px_x, px_y, done);
    end
    for (int cyc = 0; cyc < 80000; cyc++) begin
      if (px_we) begin
        if (!bad && (px_x !== ex[9:0] || px_y !== ey[9:0])) begin
          bad = 1; bx = int'(px_x); by = int'(px_y);
        end
        if (px_data !== 4'h0) data_bad = 1;
        n++; lx = int'(px_x); ly = int'(px_y);
        ex++;
        if (ex == 320) begin ex = 0; ey++; end
      end
      if (cmd_ready) begin
        ready_seen = 1; ready_ok = prev_we;
        break;
      end
      prev_we = px_we;
      if (n == 1000) start = 1'b1;
      if (n == 1004) start = 1'b0;
      step();
    end
    start = 1'b0;
    vectors++;
    if (n != 76800) begin
      miscompares++; $display("FAIL clear_count: got %0d want 76800", n);
    end
    vectors++;
    if (lx != 319 || ly != 239) begin
      miscompares++; $display("FAIL clear_last: got (%0d,%0d) want (319,239)", lx, ly);
    end
    vectors++;
    if (bad) begin
      miscompares++; $display("FAIL clear_order: first bad write (%0d,%0d) want raster order", bx, by);
    end
    vectors++;
    if (data_bad) begin
      miscompares++; $display("FAIL clear_data: got nonzero pixel want 0");
    end
    vectors++;
    if (!ready_seen || !ready_ok) begin
      miscompares++;
      $display("FAIL clear_ready: seen=%b after_last_write=%b want 1 1", ready_seen, ready_ok);
    end
  endtask

  task automatic test_clip();
    int n = 0, ex = 300, ey = 230, lx = -1, ly = -1;
    bit to, bad = 0, data_bad = 0, prev_we = 0, ready_ok = 0;
    issue_cmd(10'd300, 10'd230, 10'd400, 10'd500, 4'h5, 1'b0, to);
    vectors++;
    if (to) begin
      miscompares++; $display("FAIL clip_accept: got timeout want cmd_ready");
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (px_we) begin
        if (px_x !== ex[9:0] || px_y !== ey[9:0]) bad = 1;
        if (px_data !== 4'h5) data_bad = 1;
        n++; lx = int'(px_x); ly = int'(px_y);
        ex++;
        if (ex == 320) begin ex = 300; ey++; end
      end
      if (cmd_ready) begin ready_ok = prev_we; break; end
      prev_we = px_we;
      step();
    end
    vectors++;
    if (n != 200) begin
      miscompares++; $display("FAIL clip_count: got %0d want 200", n);
    end
    vectors++;
    if (lx != 319 || ly != 239 || bad) begin
      miscompares++; $display("FAIL clip_order: last (%0d,%0d) order_err=%b want (319,239) 0", lx, ly, bad);
    end
    vectors++;
    if (data_bad || !ready_ok || done !== 1'b0) begin
      miscompares++;
      $display("FAIL clip_tail: data_err=%b ready_after_last=%b done=%b want 0 1 0", data_bad, ready_ok, done);
    end
  endtask

  task automatic test_empty();
    bit to;
    issue_cmd(10'd50, 10'd0, 10'd40, 10'd0, 4'h7, 1'b0, to);
    vectors++;
    if (to || px_we !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_c1: timeout=%b we=%b ready=%b want 0 0 0", to, px_we, cmd_ready);
    end
    step();
    vectors++;
    if (px_we !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL empty_c2: we=%b ready=%b want 0 1", px_we, cmd_ready);
    end
    vectors++;
    if (px_x !== 10'd319 || px_y !== 10'd239 || px_data !== 4'h5) begin
      miscompares++;
      $display("FAIL empty_hold: got (%0d,%0d,%0d) want (319,239,5)", px_x, px_y, px_data);
    end
  endtask

  task automatic test_small_fill();
    int exp_x[6] = '{10, 11, 12, 10, 11, 12};
    int exp_y[6] = '{20, 20, 20, 21, 21, 21};
    int wx[8], wy[8];
    int n = 0;
    bit to, data_bad = 0, prev_we = 0, done_ok = 0, done_seen = 0;
    issue_cmd(10'd10, 10'd20, 10'd12, 10'd21, 4'h9, 1'b1, to);
    vectors++;
    if (to) begin
      miscompares++; $display("FAIL small_accept: got timeout want cmd_ready");
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (px_we) begin
        if (n < 8) begin wx[n] = int'(px_x); wy[n] = int'(px_y); end
        if (px_data !== 4'h9) data_bad = 1;
        n++;
      end
      if (done) begin done_seen = 1; done_ok = prev_we; break; end
      prev_we = px_we;
      step();
    end
    vectors++;
    if (n != 6) begin
      miscompares++; $display("FAIL small_count: got %0d want 6", n);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= n || wx[i] != exp_x[i] || wy[i] != exp_y[i]) begin
        miscompares++;
        $display("FAIL small_pixel[%0d]: got (%0d,%0d) want (%0d,%0d)", i, wx[i], wy[i], exp_x[i], exp_y[i]);
      end
    end
    vectors++;
    if (data_bad || !done_seen || !done_ok || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL small_done: data_err=%b done=%b after_last=%b ready=%b want 0 1 1 0",
               data_bad, done_seen, done_ok, cmd_ready);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    start = 1'b1;
    step();
    vectors++;
    if (px_we !== 1'b1 || px_x !== 10'd0 || px_y !== 10'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame2_first: we=%b (%0d,%0d) done=%b want 1 (0,0) 0", px_we, px_x, px_y, done);
    end
    for (int k = 0; k < 500; k++) begin
      if (k == 50) start = 1'b0;
      step();
    end
    vectors++;
    if (px_we !== 1'b1 || px_x !== 10'd180 || px_y !== 10'd1) begin
      miscompares++;
      $display("FAIL frame2_progress: we=%b (%0d,%0d) want 1 (180,1)", px_we, px_x, px_y);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (done !== 1'b1 || px_we !== 1'b0 || cmd_ready !== 1'b0 || px_x !== 10'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: done=%b we=%b ready=%b x=%0d want 1 0 0 0", done, px_we, cmd_ready, px_x);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step();
    vectors++;
    if (done !== 1'b1 || px_we !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: done=%b we=%b want 1 0", done, px_we);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_clip();
    test_empty();
    test_small_fill();
    test_start_ignored_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
